// File: rtl/serial_port.sv
// serial_port: 8N1 UART behind the CPU's COM data/status registers.
// Transmit and receive paths are independent. Each path has a four-state FSM
// (IDLE, START, DATA, STOP) that runs on a BAUD_DIV-cycle bit timer.
// Build option: define SERIAL_RX_FIFO_EN to buffer received bytes in an
// RX_FIFO_DEPTH-entry FIFO. Without it, a single holding register is used,
// and a new byte overwrites an unread one.
module serial_port #(
  parameter int BAUD_DIV      = 434,
  parameter int RX_FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       write_ready,
  output logic [7:0] rx_data,
  output logic       read_ready,
  input  logic       read_ack,
  output logic       rx_overrun,
  input  logic       rxd,
  output logic       txd
);

  localparam int            CW        = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);

  if (BAUD_DIV < 4) begin : g_baud_check
    $error("serial_port: BAUD_DIV must be >= 4");
  end
  if (RX_FIFO_DEPTH < 2 || (RX_FIFO_DEPTH & (RX_FIFO_DEPTH - 1)) != 0) begin : g_depth_check
    $error("serial_port: RX_FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_e;

  // ---------------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------------
  uart_state_e   tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q,   tx_cnt_d;
  logic [2:0]    tx_bit_q,   tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          txd_q,      txd_d;

  // TX next state: latch the byte on an accepted start, then walk the frame bits
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    txd_d      = txd_q;
    if (tx_state_q == ST_IDLE) begin
      if (tx_start) begin
        tx_state_d = ST_START;
        tx_cnt_d   = '0;
        tx_shift_d = tx_data;
        txd_d      = 1'b0;
      end
    end else if (tx_cnt_q == BIT_LAST) begin
      tx_cnt_d = '0;
      case (tx_state_q)
        ST_START: begin
          tx_state_d = ST_DATA;
          tx_bit_d   = '0;
          txd_d      = tx_shift_q[0];
        end
        ST_DATA: begin
          if (tx_bit_q == 3'd7) begin
            tx_state_d = ST_STOP;
            txd_d      = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = tx_shift_q >> 1;
            txd_d      = tx_shift_q[1];
          end
        end
        default: begin
          tx_state_d = ST_IDLE;
          txd_d      = 1'b1;
        end
      endcase
    end else begin
      tx_cnt_d = tx_cnt_q + CW'(1);
    end
  end

  // TX state register
  // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= ST_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
    end
  end

  assign txd         = txd_q;
  assign write_ready = (tx_state_q == ST_IDLE);

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  logic rxd_meta_q, rxd_meta_d;
  logic rxd_sync_q, rxd_sync_d;
  logic rxd_prev_q, rxd_prev_d;
  logic ack_prev_q, ack_prev_d;
  logic rx_fall, ack_rise, rx_pop;

  uart_state_e   rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q,   rx_cnt_d;
  logic [2:0]    rx_bit_q,   rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          rx_ferr_q,  rx_ferr_d;
  logic          rx_overrun_q, rx_overrun_d;
  logic          rx_store;

  // Synchroniser chain for rxd and previous-value taps for both edge detectors
  always_comb begin
    rxd_meta_d = rxd;
    rxd_sync_d = rxd_meta_q;
    rxd_prev_d = rxd_sync_q;
    ack_prev_d = read_ack;
  end

  assign rx_fall  = rxd_prev_q & ~rxd_sync_q;
  assign ack_rise = read_ack & ~ack_prev_q;
  assign rx_pop   = ack_rise & read_ready;

  // RX next state: qualify the start bit at half a bit, then sample mid-bit
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_ferr_d  = rx_ferr_q;
    rx_store   = 1'b0;
    case (rx_state_q)
      ST_IDLE: begin
        if (rx_fall) begin
          rx_state_d = ST_START;
          rx_cnt_d   = '0;
        end
      end
      ST_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d = '0;
          if (rxd_sync_q) begin
            rx_state_d = ST_IDLE;
          end else begin
            rx_state_d = ST_DATA;
            rx_bit_d   = '0;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      ST_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rxd_sync_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_state_d = ST_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      default: begin
        // After a framing error, hold here until the line idles high again.
        if (rx_ferr_q) begin
          if (rxd_sync_q) begin
            rx_state_d = ST_IDLE;
            rx_ferr_d  = 1'b0;
          end
        end else if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d = '0;
          if (rxd_sync_q) begin
            rx_store   = 1'b1;
            rx_state_d = ST_IDLE;
          end else begin
            rx_ferr_d = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
    endcase
  end

  // RX state register, synchroniser and read_ack history
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta_q   <= 1'b1;
      rxd_sync_q   <= 1'b1;
      rxd_prev_q   <= 1'b1;
      ack_prev_q   <= 1'b0;
      rx_state_q   <= ST_IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      rx_ferr_q    <= 1'b0;
      rx_overrun_q <= 1'b0;
    end else begin
      rxd_meta_q   <= rxd_meta_d;
      rxd_sync_q   <= rxd_sync_d;
      rxd_prev_q   <= rxd_prev_d;
      ack_prev_q   <= ack_prev_d;
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      rx_ferr_q    <= rx_ferr_d;
      rx_overrun_q <= rx_overrun_d;
    end
  end

  assign rx_overrun = rx_overrun_q;

`ifdef SERIAL_RX_FIFO_EN
  // ---------------------------------------------------------------------------
  // Receive FIFO: pop is applied before push, so a full FIFO can take a byte
  // in the same cycle one is read.
  // ---------------------------------------------------------------------------
  localparam int            PW   = $clog2(RX_FIFO_DEPTH);
  localparam logic [PW:0]   FULL = (PW + 1)'(RX_FIFO_DEPTH);

  logic [7:0]    fifo_mem_q [RX_FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q,  count_d;
  logic          fifo_push;

  // FIFO pointer/count update and overrun detection
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    rx_overrun_d = rx_overrun_q;
    fifo_push    = 1'b0;
    if (rx_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (rx_store) begin
      if (count_q == FULL && !rx_pop) begin
        rx_overrun_d = 1'b1;
      end else begin
        fifo_push = 1'b1;
        wr_ptr_d  = wr_ptr_q + PW'(1);
      end
    end
    count_d = count_q + (PW + 1)'(fifo_push) - (PW + 1)'(rx_pop);
  end

  // FIFO pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage write
  // NOTE: the storage array is not reset; only pointers/count are, and rx_data is masked while empty.
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_mem_q[wr_ptr_q] <= rx_shift_q;
    end
  end

  assign read_ready = (count_q != '0);
  assign rx_data    = read_ready ? fifo_mem_q[rd_ptr_q] : 8'h00;
`else
  // ---------------------------------------------------------------------------
  // Single holding register: a new byte overwrites an unread one.
  // ---------------------------------------------------------------------------
  logic [7:0] rx_hold_q,  rx_hold_d;
  logic       rx_valid_q, rx_valid_d;

  // Holding register update: consume first, then store
  always_comb begin
    rx_hold_d    = rx_hold_q;
    rx_valid_d   = rx_valid_q;
    rx_overrun_d = rx_overrun_q;
    if (rx_pop) begin
      rx_valid_d = 1'b0;
    end
    if (rx_store) begin
      if (rx_valid_q && !rx_pop) begin
        rx_overrun_d = 1'b1;
      end
      rx_hold_d  = rx_shift_q;
      rx_valid_d = 1'b1;
    end
  end

  // Holding register
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_hold_q  <= 8'h00;
      rx_valid_q <= 1'b0;
    end else begin
      rx_hold_q  <= rx_hold_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign read_ready = rx_valid_q;
  assign rx_data    = rx_hold_q;
`endif

endmodule

// File: tb/tb_serial_port.sv
// tb_serial_port: self-checking bench for serial_port at BAUD_DIV=16.
// Covers transmit frame timing, receive, glitch and framing-error rejection,
// overrun (holding register or FIFO, matching the build), mid-frame reset,
// loopback, and randomised receive traffic against a queue model.
`timescale 1ns/1ps
module tb_serial_port;

  localparam int BD    = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       write_ready;
  logic [7:0] rx_data;
  logic       read_ready;
  logic       read_ack = 1'b0;
  logic       rx_overrun;
  logic       rxd;
  logic       txd;
  logic       rxd_drv = 1'b1;
  logic       loopback = 1'b0;

  assign rxd = loopback ? txd : rxd_drv;

  serial_port #(.BAUD_DIV(BD), .RX_FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .write_ready(write_ready),
    .rx_data    (rx_data),
    .read_ready (read_ready),
    .read_ack   (read_ack),
    .rx_overrun (rx_overrun),
    .rxd        (rxd),
    .txd        (txd)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    logic       exp_ready;
    logic [7:0] exp_data;
  } rx_vec_t;

  rx_vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance n clock edges; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Expected line level k cycles after an accepted tx_start (k = 1..10*BD).
  function automatic logic frame_bit(input logic [7:0] d, input int k);
    int b;
    b = (k - 1) / BD;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return d[b-1];
  endfunction

  // Start a TX frame in the current cycle and check all 10*BD cycles.
  // With inject set, a tx_start for 0x55 is pulsed mid-frame and must be ignored.
  // Returns in the cycle where write_ready must be back to 1.
  task automatic tx_frame(input logic [7:0] d, input logic inject);
    tx_data  = d;
    tx_start = 1'b1;
    step(1);
    tx_start = 1'b0;
    for (int k = 1; k <= 10 * BD; k++) begin
      check($sformatf("txd[%0h] cyc %0d", d, k), txd, frame_bit(d, k));
      check($sformatf("write_ready busy[%0h] cyc %0d", d, k), write_ready, 1'b0);
      if (inject && k == 50) begin
        tx_data  = 8'h55;
        tx_start = 1'b1;
      end else begin
        tx_start = 1'b0;
      end
      step(1);
    end
    check($sformatf("write_ready back[%0h]", d), write_ready, 1'b1);
  endtask

  // Drive frame bits first..last (0 = start, 1..8 = data, 9 = stop) on rxd.
  task automatic drive_frame(input logic [7:0] d, input logic stop_bit, input int first, input int last);
    for (int b = first; b <= last; b++) begin
      if (b == 0)      rxd_drv = 1'b0;
      else if (b == 9) rxd_drv = stop_bit;
      else             rxd_drv = d[b-1];
      step(BD);
    end
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stop_bit);
    drive_frame(d, stop_bit, 0, 9);
  endtask

  task automatic pop();
    read_ack = 1'b1;
    step(1);
    read_ack = 1'b0;
    step(1);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    rxd_drv  = 1'b1;
    tx_start = 1'b0;
    read_ack = 1'b0;
    step(2);
    rst = 1'b0;
    step(3);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q[$];
    logic       m_ovr;
    logic [7:0] b;
    logic [7:0] e;
    int         np;

    vecs[0] = '{8'h00, 1'b1, 1'b1, 8'h00};
    vecs[1] = '{8'hA7, 1'b0, 1'b0, 8'h00};
    vecs[2] = '{8'hFF, 1'b1, 1'b1, 8'hFF};
    vecs[3] = '{8'h81, 1'b0, 1'b0, 8'h00};
    vecs[4] = '{8'h5A, 1'b1, 1'b1, 8'h5A};
    vecs[5] = '{8'h01, 1'b1, 1'b1, 8'h01};

    // Reset state
    step(3);
    check("reset txd", txd, 1'b1);
    check("reset write_ready", write_ready, 1'b1);
    check("reset read_ready", read_ready, 1'b0);
    check("reset rx_data", rx_data, 8'h00);
    check("reset rx_overrun", rx_overrun, 1'b0);
    rst = 1'b0;
    step(2);

    // TX: 0xA5, then a frame with an ignored mid-frame tx_start, then back-to-back
    tx_frame(8'hA5, 1'b0);
    tx_frame(8'h3C, 1'b1);
    tx_frame(8'hC3, 1'b0);
    step(3);
    check("tx idle txd", txd, 1'b1);

    // RX 0x3C: not ready before the stop bit, ready after; read_ack held 5 cycles
    drive_frame(8'h3C, 1'b1, 0, 8);
    check("rx 3C not ready before stop", read_ready, 1'b0);
    drive_frame(8'h3C, 1'b1, 9, 9);
    check("rx 3C read_ready", read_ready, 1'b1);
    check("rx 3C rx_data", rx_data, 8'h3C);
    read_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check($sformatf("ack held read_ready cyc %0d", i), read_ready, 1'b0);
    end
    read_ack = 1'b0;
    step(1);
    check("ack held rx_overrun", rx_overrun, 1'b0);

    // Glitch: 2-cycle low pulse must not produce a byte; next frame still received
    rxd_drv = 1'b0;
    step(2);
    rxd_drv = 1'b1;
    step(40);
    check("glitch read_ready", read_ready, 1'b0);
    send_rx(8'h96, 1'b1);
    check("post-glitch read_ready", read_ready, 1'b1);
    check("post-glitch rx_data", rx_data, 8'h96);
    pop();
    check("post-glitch popped", read_ready, 1'b0);

    // Table: valid frames and framing errors
    for (int i = 0; i < 6; i++) begin
      send_rx(vecs[i].data, vecs[i].stop_bit);
      if (!vecs[i].stop_bit) begin
        step(20);
        rxd_drv = 1'b1;
        step(10);
      end else begin
        step(2);
      end
      check($sformatf("vec%0d read_ready", i), read_ready, vecs[i].exp_ready);
      check($sformatf("vec%0d rx_overrun", i), rx_overrun, 1'b0);
      if (vecs[i].exp_ready) begin
        check($sformatf("vec%0d rx_data", i), rx_data, vecs[i].exp_data);
        pop();
        check($sformatf("vec%0d popped", i), read_ready, 1'b0);
      end
    end

    // Overrun
`ifdef SERIAL_RX_FIFO_EN
    for (int i = 1; i <= 5; i++) begin
      e = 8'(i * 8'h11);
      send_rx(e, 1'b1);
    end
    step(2);
    check("fifo overrun", rx_overrun, 1'b1);
    check("fifo ready", read_ready, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      e = 8'(i * 8'h11);
      check($sformatf("fifo order %0d", i), rx_data, e);
      pop();
    end
    check("fifo drained", read_ready, 1'b0);
`else
    send_rx(8'h11, 1'b1);
    check("overrun first no flag", rx_overrun, 1'b0);
    send_rx(8'h22, 1'b1);
    step(2);
    check("overrun rx_data", rx_data, 8'h22);
    check("overrun flag", rx_overrun, 1'b1);
    check("overrun ready", read_ready, 1'b1);
`endif

    // Reset mid-TX and mid-RX frame
    do_reset();
    check("overrun cleared by rst", rx_overrun, 1'b0);
    send_rx(8'h5A, 1'b1);
    check("pre-rst ready", read_ready, 1'b1);
    tx_data  = 8'h81;
    tx_start = 1'b1;
    step(1);
    tx_start = 1'b0;
    rxd_drv  = 1'b0;
    step(30);
    check("mid-frame write_ready busy", write_ready, 1'b0);
    rst     = 1'b1;
    rxd_drv = 1'b1;
    step(1);
    check("rst mid txd", txd, 1'b1);
    check("rst mid write_ready", write_ready, 1'b1);
    check("rst mid read_ready", read_ready, 1'b0);
    check("rst mid rx_overrun", rx_overrun, 1'b0);
    rst = 1'b0;
    step(5);

    // Loopback 0xFF
    loopback = 1'b1;
    tx_frame(8'hFF, 1'b0);
    step(10);
    check("loopback read_ready", read_ready, 1'b1);
    check("loopback rx_data", rx_data, 8'hFF);
    pop();
    loopback = 1'b0;
    step(2);

    // Randomised receive traffic against a queue model
    do_reset();
    m_ovr = 1'b0;
    for (int it = 0; it < 14; it++) begin
      b = 8'($urandom);
      step($urandom_range(0, 5));
      send_rx(b, 1'b1);
`ifdef SERIAL_RX_FIFO_EN
      if (q.size() == DEPTH) m_ovr = 1'b1;
      else q.push_back(b);
`else
      if (q.size() != 0) begin
        m_ovr = 1'b1;
        q[0]  = b;
      end else begin
        q.push_back(b);
      end
`endif
      check($sformatf("rand%0d rx_overrun", it), rx_overrun, m_ovr);
      check($sformatf("rand%0d read_ready", it), read_ready, q.size() != 0);
      np = $urandom_range(0, 2);
      for (int p = 0; p < np; p++) begin
        if (q.size() != 0) begin
          check($sformatf("rand%0d rx_data pop%0d", it, p), rx_data, q[0]);
          void'(q.pop_front());
        end
        pop();
        check($sformatf("rand%0d ready after pop%0d", it, p), read_ready, q.size() != 0);
      end
    end

    // Randomised transmit bytes
    for (int it = 0; it < 3; it++) begin
      tx_frame(8'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_port.md
Name: serial_port

Overview:
- 8N1 UART serving the CPU's COM data/status registers; sits directly downstream of the physical memory controller.
- Consumes the controller's one-cycle write strobe, byte, and read-acknowledge level.
- Produces the received byte, read_ready / write_ready status, and the serial txd line.
- All logic runs on posedge clk; memory-controller strobes last one full cycle, so each is sampled exactly once.

Parameters:
BAUD_DIV, 434, clk cycles per bit (50 MHz / 115200); must be >= 4
RX_FIFO_DEPTH, 4, receive FIFO entries; used only with SERIAL_RX_FIFO_EN; power of two

Ports:
clk  in  1  50 MHz system clock
rst  in  1  reset
tx_data  in  8  byte to transmit (memory controller's latched write byte)
tx_start  in  1  one-cycle request to send tx_data
write_ready  out  1  transmitter idle, can accept tx_start
rx_data  out  8  oldest received byte
read_ready  out  1  at least one received byte pending
read_ack  in  1  level, high while CPU reads COM data; rising edge consumes one byte
rx_overrun  out  1  sticky: a byte was lost
rxd  in  1  asynchronous serial input, idle high
txd  out  1  serial output, idle high

Behaviour:
- Reset: rst is synchronous, active-high.
  - Outputs at reset: txd=1, write_ready=1, read_ready=0, rx_data=0, rx_overrun=0.
  - Both FSMs go to IDLE and all counters clear.
  - rst mid-frame aborts the frame immediately; txd returns high on the next cycle.
- TX FSM (IDLE, START, DATA, STOP):
  - tx_start sampled high in IDLE at cycle N latches tx_data and sets write_ready=0 from N+1.
  - txd=0 during cycles N+1 .. N+BAUD_DIV.
  - Data bits go out LSB first, each held BAUD_DIV cycles.
  - Stop bit is txd=1 for BAUD_DIV cycles.
  - write_ready returns to 1 at cycle N+1+10*BAUD_DIV; a tx_start in that same cycle is accepted (back-to-back frames, no idle gap).
  - tx_start while write_ready=0 is ignored; the latched byte is not modified.
- RX synchroniser: rxd passes through a 2-flop synchroniser (2-cycle latency). A falling-edge detector runs on the synchronised signal.
- RX FSM (IDLE, START, DATA, STOP):
  - IDLE -> START on a synchronised falling edge.
  - START waits BAUD_DIV/2 cycles (integer divide). If the line is back to 1, it is a glitch: return to IDLE, no data.
  - DATA samples every BAUD_DIV cycles thereafter, 8 bits shifted in LSB first.
  - STOP samples once after a further BAUD_DIV. 1 = valid: byte stored. 0 = framing error: byte discarded, FSM waits for the line to return to 1 before re-entering IDLE.
  - For a stored byte, read_ready rises on the cycle after the stop sample.
- Read handshake:
  - read_ack is edge-detected (registered previous value).
  - A rising edge with read_ready=1 consumes the byte and clears read_ready next cycle.
  - A rising edge with read_ready=0 has no effect.
  - Holding read_ack high consumes only one byte.
- Simultaneous store and consume in the same cycle: consume applies first, then store. read_ready stays 1 and rx_data shows the new byte.
- rx_overrun: set when a valid byte arrives with no room to store it; cleared only by rst.
- tx and rx paths are fully independent; a loopback of txd to rxd must work.

Optional Feature:
SERIAL_RX_FIFO_EN
- Defined:
  - Receive path uses an RX_FIFO_DEPTH-entry FIFO; rx_data shows the head entry.
  - read_ready = not empty; a read_ack rising edge pops one entry.
  - A stop-valid byte arriving when the FIFO is full is dropped; existing contents are kept and rx_overrun is set.
  - Push and pop in the same cycle when full is legal: count unchanged, no overrun.
- Undefined: single-byte holding register.
  - A new byte while read_ready=1 overwrites rx_data and sets rx_overrun.

Test Plan (BAUD_DIV=16):
- Reset, then tx_start with tx_data=0xA5 at cycle N -> txd low N+1..N+16, then bits 1,0,1,0,0,1,0,1 (16 cycles each), then stop high; write_ready=0 from N+1, back to 1 at N+161.
- Drive rxd frame 0x3C at 16-cycle bit time -> read_ready=1 one cycle after stop sample, rx_data=0x3C; read_ack held high 5 cycles -> read_ready=0 after first edge only, rx_overrun=0.
- 2-cycle low glitch on rxd -> no byte stored, RX FSM back in IDLE; frame with stop bit 0 -> byte discarded, read_ready stays 0.
- Receive 0x11 then 0x22 without read_ack:
  - FIFO off -> rx_data=0x22, rx_overrun=1.
  - FIFO on, 5 bytes 0x11..0x55 -> bytes 0x11..0x44 pop in order, 0x55 is lost, rx_overrun=1.
- tx_start for 0x55 while a previous frame is transmitting -> ignored, first frame's bits unchanged; tx_start in the cycle write_ready returns -> new frame starts next cycle.
- rst asserted mid-TX and mid-RX frame -> txd=1, write_ready=1, read_ready=0 the next cycle; a subsequent loopback frame 0xFF is received correctly.
